// File: rtl/fetch_buffered_pkg.sv
// Shared constants and helpers for the buffered fetch stage and its ring storage.
package fetch_buffered_pkg;

    localparam int NOP_INSTR        = 0;
    localparam int RESET_PC_DEFAULT = 0;

    // One extra bit so a full ring (alloc - rd == DEPTH) is distinguishable from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffered_ring.sv
// In-order fetch ring: DEPTH x {pc, instr, filled} with alloc/fill/rd pointers and a bulk clear.
module fetch_buffered_ring
    import fetch_buffered_pkg::*;
#(
    parameter int PC_WIDTH   = 12,
    parameter int PMEM_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int PW        = ptr_width(DEPTH),
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  alloc,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    input  logic                  fill,
    input  logic [PMEM_WIDTH-1:0] fill_instr,
    input  logic                  pop,
    output logic                  head_filled,
    output logic [PC_WIDTH-1:0]   head_pc,
    output logic [PMEM_WIDTH-1:0] head_instr,
    output logic [PW-1:0]         used,
    output logic [PW-1:0]         unfilled
);

    logic [PW-1:0]         alloc_q, alloc_d;
    logic [PW-1:0]         fill_q, fill_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [DEPTH-1:0]      filled_q, filled_d;
    logic [PC_WIDTH-1:0]   pc_mem [DEPTH];
    logic [PMEM_WIDTH-1:0] instr_mem [DEPTH];

    logic [IW-1:0] alloc_idx, fill_idx, rd_idx;

    assign fill_idx  = fill_q[IW-1:0];
    assign rd_idx    = rd_q[IW-1:0];
    // A same-cycle allocation after clear lands in slot 0 of the fresh stream.
    assign alloc_idx = clear ? '0 : alloc_q[IW-1:0];

    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        if (clear) begin
            alloc_d = '0;
            fill_d  = '0;
            rd_d    = '0;
        end else begin
            if (fill) fill_d = fill_q + 1'b1;
            if (pop)  rd_d   = rd_q + 1'b1;
        end
        if (alloc) alloc_d = alloc_d + 1'b1;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
            always_comb begin
                filled_d[gi] = filled_q[gi];
                if (clear) begin
                    filled_d[gi] = 1'b0;
                end else begin
                    if (pop && rd_idx == IW'(gi))   filled_d[gi] = 1'b0;
                    if (fill && fill_idx == IW'(gi)) filled_d[gi] = 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            rd_q     <= '0;
            filled_q <= '0;
        end else begin
            alloc_q  <= alloc_d;
            fill_q   <= fill_d;
            rd_q     <= rd_d;
            filled_q <= filled_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && alloc)          pc_mem[alloc_idx]   <= alloc_pc;
        if (reset && fill && !clear) instr_mem[fill_idx] <= fill_instr;
    end

    assign head_filled = filled_q[rd_idx];
    assign head_pc     = pc_mem[rd_idx];
    assign head_instr  = instr_mem[rd_idx];
    assign used        = alloc_q - rd_q;
    assign unfilled    = alloc_q - fill_q;

endmodule

// File: rtl/fetch_buffered.sv
// Buffered fetch stage: issues pmem requests ahead of decode into an in-order ring,
// discarding responses that belong to a flushed or redirected stream.
module fetch_buffered
    import fetch_buffered_pkg::*;
#(
    parameter int PC_WIDTH     = 12,
    parameter int PMEM_WIDTH   = 16,
    parameter int PC_INCREMENT = 2,
    parameter int DEPTH        = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_flush,
    input  logic                  in_set_pc,
    input  logic [PC_WIDTH-1:0]   in_branch_pc,
    input  logic                  in_stall,
    output logic                  out_pmem_req,
    output logic [PC_WIDTH-1:0]   out_pmem_addr,
    input  logic                  in_pmem_valid,
    input  logic [PMEM_WIDTH-1:0] in_pmem_instr,
    output logic                  out_valid,
    output logic [PMEM_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]   out_pc
);

    localparam int PW = ptr_width(DEPTH);

    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]         drop_cnt_q, drop_cnt_d;
    logic                  redirect, pop, issue, keep;
    logic [PW-1:0]         used, unfilled, used_after;
    logic [PC_WIDTH-1:0]   req_addr;
    logic                  head_filled;
    logic [PC_WIDTH-1:0]   head_pc;
    logic [PMEM_WIDTH-1:0] head_instr;

    assign redirect   = in_flush || in_set_pc;
    assign out_valid  = reset && head_filled && !redirect;
    assign pop        = out_valid && !in_stall;
    assign used_after = redirect ? '0 : used - PW'(pop);
    assign issue      = reset && (used_after < PW'(DEPTH));
    assign req_addr   = in_set_pc ? in_branch_pc : fetch_pc_q;
    assign keep       = reset && in_pmem_valid && (drop_cnt_q == '0) && !redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (issue)          fetch_pc_d = req_addr + PC_WIDTH'(PC_INCREMENT);
        else if (in_set_pc) fetch_pc_d = in_branch_pc;

        // Everything still in flight belongs to the old stream once we redirect.
        drop_cnt_d = drop_cnt_q;
        if (redirect)
            drop_cnt_d = drop_cnt_q + unfilled - PW'(in_pmem_valid);
        else if (in_pmem_valid && drop_cnt_q != '0)
            drop_cnt_d = drop_cnt_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_buffered_ring #(
        .PC_WIDTH   (PC_WIDTH),
        .PMEM_WIDTH (PMEM_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ring (
        .clock       (clock),
        .reset       (reset),
        .clear       (redirect),
        .alloc       (issue),
        .alloc_pc    (req_addr),
        .fill        (keep),
        .fill_instr  (in_pmem_instr),
        .pop         (pop),
        .head_filled (head_filled),
        .head_pc     (head_pc),
        .head_instr  (head_instr),
        .used        (used),
        .unfilled    (unfilled)
    );

    assign out_pmem_req  = issue;
    assign out_pmem_addr = reset ? req_addr : '0;
    assign out_instr     = out_valid ? head_instr : PMEM_WIDTH'(NOP_INSTR);
    assign out_pc        = reset ? head_pc : '0;

endmodule
